// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines and zero-cycle hits.
// Optional build macro DCACHE_STATS_EN adds hit_count/miss_count counter ports.
module dcache_direct #(
    parameter int INDEX_WIDTH = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    input  logic         write_enable,
    input  logic         read_enable,
    output logic [31:0]  rdata,
    output logic         miss,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int NLINES = 1 << INDEX_WIDTH;
    localparam int TAG_W  = 28 - INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t state_q, state_d;

    logic [NLINES-1:0] valid_q, valid_d;
    logic [NLINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [3:0][31:0]  data_q [NLINES];

    logic [127:0] line_q, line_d;
    logic         mem_req_q, mem_req_d;
    logic         mem_we_q, mem_we_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             off;
    logic req, hit, ack, idle_miss, wr_hit, fill;
    logic unused_ok;

    assign idx       = addr[3+INDEX_WIDTH:4];
    assign tag       = addr[31:4+INDEX_WIDTH];
    assign off       = addr[3:2];
    assign req       = read_enable | write_enable;
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    // An ack with no outstanding request is dropped here.
    assign ack       = mem_ack & mem_req_q;
    assign idle_miss = (state_q == IDLE) & req & ~hit;
    assign wr_hit    = (state_q == IDLE) & write_enable & hit;
    assign fill      = (state_q == REFILL);
    assign unused_ok = ^addr[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (idle_miss) state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (ack) state_d = ALLOCATE;
            ALLOCATE:  if (ack) state_d = REFILL;
            REFILL:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        miss  = req & ((state_q != IDLE) | ~hit);
        rdata = '0;
        if (read_enable && !write_enable && !miss) rdata = data_q[idx][off];
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_d      = line_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        if (idle_miss) begin
            mem_req_d = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {tag_q[idx], idx, 4'b0};
                mem_wdata_d = data_q[idx];
            end else begin
                mem_we_d   = 1'b0;
                mem_addr_d = {addr[31:4], 4'b0};
            end
        end
        // Writeback done: relaunch straight into the refill read, req stays high.
        if (state_q == WRITEBACK && ack) begin
            dirty_d[idx] = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = {addr[31:4], 4'b0};
        end
        if (state_q == ALLOCATE && ack) begin
            mem_req_d = 1'b0;
            line_d    = mem_rdata;
        end
        if (wr_hit) dirty_d[idx] = 1'b1;
        if (fill) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            line_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            line_q      <= line_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag/data storage carries no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_q;
        end else if (wr_hit) begin
            data_q[idx][off] <= wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, (state_q == IDLE) & req & hit};
        miss_count_d = miss_count_q + {31'd0, idle_miss};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
